// File: rtl/regfile_mp_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_mp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_t;

    localparam int DATA_W_DEF   = 32;
    localparam int DEPTH_DEF    = 32;
    localparam int N_RD_DEF     = 2;
    localparam int ZERO_REG_DEF = 1;
    localparam int N_WR         = 2;

endpackage

// File: rtl/regfile_mp_clr.sv
// Clear-sweep sequencer: walks every entry once, then pulses ClearDone.
module regfile_mp_clr
    import regfile_mp_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Clear,
    output logic              Busy,
    output logic              ClearDone,
    output logic              ClrEn,
    output logic [ADDR_W-1:0] ClrAddr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    clr_state_t        state;
    clr_state_t        state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nx;
    logic              done;
    logic              done_nx;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            ptr   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Clear) begin
                    state_nx = SWEEP;
                    ptr_nx   = '0;
                end
            end
            SWEEP: begin
                ptr_nx = ptr + 1'b1;
                if (ptr == LAST) begin
                    state_nx = IDLE;
                    ptr_nx   = '0;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign Busy      = (state == SWEEP);
    assign ClrEn     = (state == SWEEP);
    assign ClrAddr   = ptr;
    assign ClearDone = done;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with synchronous clear sweep.
// Define REGFILE_MP_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int N_RD     = N_RD_DEF,
    parameter  int ZERO_REG = ZERO_REG_DEF,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [N_RD*ADDR_W-1:0] ReadAddr,
    output logic [N_RD*DATA_W-1:0] ReadData,
    input  logic [N_WR-1:0]        WriteEn,
    input  logic [N_WR*ADDR_W-1:0] WriteAddr,
    input  logic [N_WR*DATA_W-1:0] WriteData,
    input  logic                   Clear,
    output logic                   Busy,
    output logic                   ClearDone
);

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] wa [N_WR];
    logic [DATA_W-1:0] wd [N_WR];
    logic [N_WR-1:0]   wr_ok;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    regfile_mp_clr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr (
        .Clock     (Clock),
        .Reset     (Reset),
        .Clear     (Clear),
        .Busy      (Busy),
        .ClearDone (ClearDone),
        .ClrEn     (clr_en),
        .ClrAddr   (clr_addr)
    );

    // Writes are blocked during the sweep and on the cycle it is accepted.
    for (genvar p = 0; p < N_WR; p++) begin : g_wr
        assign wa[p]    = WriteAddr[p*ADDR_W +: ADDR_W];
        assign wd[p]    = WriteData[p*DATA_W +: DATA_W];
        assign wr_ok[p] = WriteEn[p] && !Busy && !Clear && addr_ok(wa[p]);
    end

    // Later ports overwrite earlier ones, so port 1 wins on a collision.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int p = 0; p < N_WR; p++) begin
                if (wr_ok[p]) mem[wa[p]] <= wd[p];
            end
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = ReadAddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            if (addr_ok(ra)) rd = mem[ra];
            if (BYPASS) begin
                for (int p = 0; p < N_WR; p++) begin
                    if (wr_ok[p] && (wa[p] == ra)) rd = wd[p];
                end
            end
        end

        assign ReadData[k*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (2..256).
REQ-003 SHALL have parameter N_RD, default 2, number of asynchronous read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as 0 and ignores writes.
REQ-005 SHALL derive localparam ADDR_W = clog2(DEPTH).
REQ-006 Clock  in  1  rising-edge clock for all writes and the clear sweep.
REQ-007 Reset  in  1  asynchronous, active-high; zeroes all registers and returns the FSM to IDLE.
REQ-008 ReadAddr  in  N_RD*ADDR_W  packed read addresses; port k uses slice k.
REQ-009 ReadData  out  N_RD*DATA_W  packed read data; port k uses slice k.
REQ-010 WriteEn  in  2  per-write-port enable (port 0, port 1).
REQ-011 WriteAddr  in  2*ADDR_W  packed write addresses.
REQ-012 WriteData  in  2*DATA_W  packed write data.
REQ-013 Clear  in  1  single-cycle request to start a synchronous clear sweep.
REQ-014 Busy  out  1  high while the sweep runs.
REQ-015 ClearDone  out  1  one-cycle pulse on the cycle after the last entry is cleared.

Function
REQ-016 Reads SHALL be combinational, with zero-cycle latency from ReadAddr to ReadData.
REQ-017 A read of address 0 with ZERO_REG=1 SHALL return 0.
REQ-018 A read of an address >= DEPTH SHALL return 0.
REQ-019 A port with WriteEn[p]=1 SHALL write WriteData[p] at WriteAddr[p] on the rising Clock edge.
REQ-020 Writes to address 0 (ZERO_REG=1) or to an address >= DEPTH SHALL be dropped silently.
REQ-021 When both ports write the same address in the same cycle, port 1 SHALL win.
REQ-022 Writes to different addresses in the same cycle SHALL both commit.
REQ-023 The FSM SHALL have states IDLE and SWEEP.
REQ-024 IDLE->SWEEP SHALL occur when Clear=1 in IDLE; the pointer is loaded with 0.
REQ-025 In SWEEP, each cycle SHALL zero entry[ptr] and increment ptr.
REQ-026 At ptr=DEPTH-1, the FSM SHALL return to IDLE and pulse ClearDone on the next cycle; a sweep therefore takes DEPTH cycles.
REQ-027 Busy SHALL equal (state==SWEEP).
REQ-028 Clear asserted while Busy=1 SHALL be ignored.
REQ-029 All WriteEn SHALL be ignored while Busy=1, including on the cycle Clear is accepted in IDLE.
REQ-030 Reads during SWEEP SHALL return current contents: 0 for entries already swept, old values otherwise.

Reset
REQ-031 Reset SHALL asynchronously force all registers to 0, state to IDLE, ptr to 0, Busy=0 and ClearDone=0.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep, and no ClearDone SHALL be issued.
REQ-033 The first write SHALL commit on the first rising edge after Reset deasserts.

Configuration
REQ-034 The macro REGFILE_MP_BYPASS_EN SHALL control write-to-read forwarding.
REQ-035 With REGFILE_MP_BYPASS_EN defined, a read whose address matches an enabled, non-dropped write in the same cycle SHALL return that WriteData, with port 1 taking priority.
REQ-036 Forwarding SHALL be suppressed while Busy=1 and for address 0 (ZERO_REG=1).
REQ-037 Without REGFILE_MP_BYPASS_EN, reads SHALL return the pre-edge stored value, and the new value SHALL be visible after the edge.

Structure
REQ-038 Package regfile_mp_pkg SHALL hold the FSM state enum (IDLE, SWEEP), the default parameter constants and the port-count constant N_WR=2.
REQ-039 The sweep FSM and pointer SHALL live in sub-module regfile_mp_clr, with outputs Busy, ClearDone, ClrEn and ClrAddr.
REQ-040 Storage, the write arbitration and the read muxes SHALL remain in regfile_mp.

Verification
REQ-041 Reset, then write port 0 addr 5 = 0xDEADBEEF -> ReadAddr[0]=5 returns 0xDEADBEEF after the edge; addr 0 reads 0.
REQ-042 Same-cycle write port 0 addr 7 = 0x11, port 1 addr 7 = 0x22 -> addr 7 reads 0x22; same cycle to addrs 3/4 -> both commit.
REQ-043 Write addr 0 = 0xFFFFFFFF with ZERO_REG=1 -> reads 0; with DEPTH=20, write addr 25 -> dropped, and a read of 25 returns 0.
REQ-044 Fill all entries, then pulse Clear -> Busy high for 32 cycles, ClearDone pulses once, all reads 0, and a write during Busy is lost.
REQ-045 Assert Reset at sweep cycle 10 -> Busy=0 immediately, no ClearDone, all entries 0.
REQ-046 With REGFILE_MP_BYPASS_EN, write addr 9 = 0xA5A5A5A5 while reading 9 -> same-cycle ReadData=0xA5A5A5A5; without the macro, the old value is returned until the edge.
